i2c_tx_fifo: RTL and testbench

//  - TX data buffer between the APB slave interface and the I2C core. It sits directly downstream of the APB slave interface.
//  - Captures WRITE_DATA_ON_TX on every WR_ENA strobe and holds the words in order.
//  - The I2C core pops one word per RD_EN pulse.
//  - Returns TX_EMPTY to the APB slave interface, which drives INT_TX from it.

---
 rtl/apb_i2c_pkg.sv | 15 +
 rtl/i2c_fifo_mem.sv | 36 +++
 rtl/i2c_tx_fifo.sv | 89 ++++++++
 tb/tb_i2c_tx_fifo.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/apb_i2c_pkg.sv
// Shared constants and types for the APB-to-I2C bridge: bus width, FIFO sizing
// and the register map.
package apb_i2c_pkg;

    localparam int APB_DWIDTH    = 32;
    localparam int TX_FIFO_DEPTH = 16;

    localparam logic [7:0] ADDR_TX  = 8'd0;
    localparam logic [7:0] ADDR_RX  = 8'd4;
    localparam logic [7:0] ADDR_CFG = 8'd8;
    localparam logic [7:0] ADDR_TMO = 8'd12;

    typedef logic [APB_DWIDTH-1:0] apb_word_t;

endpackage

// File: rtl/i2c_fifo_mem.sv
// DEPTH x DWIDTH register array with one synchronous write port and one registered
// read port; shared by the TX and RX FIFOs. The array itself is never reset.
module i2c_fifo_mem
    import apb_i2c_pkg::*;
#(
    parameter int DWIDTH = APB_DWIDTH,
    parameter int DEPTH  = TX_FIFO_DEPTH
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DWIDTH-1:0]        wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DWIDTH-1:0]        rd_data_p1
);

    logic [DWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge PCLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register is cleared so the popped-word output starts at zero; it holds between reads.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            rd_data_p1 <= '0;
        end else if (rd_en) begin
            rd_data_p1 <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/i2c_tx_fifo.sv
// TX word buffer between the APB slave and the I2C core. Define I2C_TX_FIFO_OVF_EN
// to add the sticky TX_OVERFLOW flag.
module i2c_tx_fifo
    import apb_i2c_pkg::*;
#(
    parameter int DWIDTH = APB_DWIDTH,
    parameter int DEPTH  = TX_FIFO_DEPTH
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    input  logic                   WR_ENA,
    input  logic [DWIDTH-1:0]      WRITE_DATA_ON_TX,
    input  logic                   RD_EN,
    output logic [DWIDTH-1:0]      DATA_OUT,
    output logic                   DATA_VALID,
    output logic                   TX_EMPTY,
    output logic                   TX_FULL,
    output logic [$clog2(DEPTH):0] TX_COUNT
`ifdef I2C_TX_FIFO_OVF_EN
    ,
    output logic                   TX_OVERFLOW
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;
    logic          push_ok;
    logic          pop_ok;

    // A full FIFO still accepts a push when a pop frees the slot in the same cycle.
    always_comb begin
        pop_ok    = RD_EN && !TX_EMPTY;
        push_ok   = WR_ENA && (!TX_FULL || pop_ok);
        count_nxt = count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            TX_EMPTY   <= 1'b1;
            TX_FULL    <= 1'b0;
            DATA_VALID <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count      <= count_nxt;
            TX_EMPTY   <= (count_nxt == '0);
            TX_FULL    <= (count_nxt == (AW+1)'(DEPTH));
            DATA_VALID <= pop_ok;
        end
    end

`ifdef I2C_TX_FIFO_OVF_EN
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            TX_OVERFLOW <= 1'b0;
        end else if (WR_ENA && TX_FULL) begin
            TX_OVERFLOW <= 1'b1;
        end
    end
`endif

    assign TX_COUNT = count;

    i2c_fifo_mem #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_mem (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .wr_en      (push_ok),
        .wr_addr    (wr_ptr),
        .wr_data    (WRITE_DATA_ON_TX),
        .rd_en      (pop_ok),
        .rd_addr    (rd_ptr),
        .rd_data_p1 (DATA_OUT)
    );

endmodule

// File: tb/tb_i2c_tx_fifo.sv
// Directed bench for i2c_tx_fifo with a queue-based reference of the FIFO contents.
module tb_i2c_tx_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          WR_ENA;
    logic [DW-1:0] WRITE_DATA_ON_TX;
    logic          RD_EN;
    logic [DW-1:0] DATA_OUT;
    logic          DATA_VALID;
    logic          TX_EMPTY;
    logic          TX_FULL;
    logic [4:0]    TX_COUNT;
    logic          TX_OVERFLOW;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] sb[$];
    logic [DW-1:0] exp_dout;
    logic          exp_valid;
    logic          exp_ovf;

    always #5 PCLK = ~PCLK;

    i2c_tx_fifo #(.DWIDTH(DW), .DEPTH(DEPTH)) dut (
        .PCLK             (PCLK),
        .PRESET           (PRESET),
        .WR_ENA           (WR_ENA),
        .WRITE_DATA_ON_TX (WRITE_DATA_ON_TX),
        .RD_EN            (RD_EN),
        .DATA_OUT         (DATA_OUT),
        .DATA_VALID       (DATA_VALID),
        .TX_EMPTY         (TX_EMPTY),
        .TX_FULL          (TX_FULL),
        .TX_COUNT         (TX_COUNT)
`ifdef I2C_TX_FIFO_OVF_EN
        ,
        .TX_OVERFLOW      (TX_OVERFLOW)
`endif
    );

`ifndef I2C_TX_FIFO_OVF_EN
    assign TX_OVERFLOW = 1'b0;
`endif

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, update the reference, then compare all outputs after the edge.
    task automatic step(input logic rst, input logic wr, input logic [DW-1:0] d, input logic rd);
        int sz;
        PRESET = rst; WR_ENA = wr; WRITE_DATA_ON_TX = d; RD_EN = rd;
        sz = sb.size();
        if (rst) begin
            sb.delete();
            exp_dout  = '0;
            exp_valid = 1'b0;
            exp_ovf   = 1'b0;
        end else begin
`ifdef I2C_TX_FIFO_OVF_EN
            if (wr && sz == DEPTH) exp_ovf = 1'b1;
`endif
            exp_valid = rd && (sz > 0);
            if (exp_valid) exp_dout = sb.pop_front();
            if (wr && (sz < DEPTH || exp_valid)) sb.push_back(d);
        end
        @(posedge PCLK);
        #1;
        chk("DATA_VALID", DW'(DATA_VALID), DW'(exp_valid));
        chk("DATA_OUT", DATA_OUT, exp_dout);
        chk("TX_COUNT", DW'(TX_COUNT), DW'(sb.size()));
        chk("TX_EMPTY", DW'(TX_EMPTY), DW'(sb.size() == 0));
        chk("TX_FULL", DW'(TX_FULL), DW'(sb.size() == DEPTH));
        chk("TX_OVERFLOW", DW'(TX_OVERFLOW), DW'(exp_ovf));
    endtask

    initial begin
        PRESET = 1'b1; WR_ENA = 1'b0; WRITE_DATA_ON_TX = '0; RD_EN = 1'b0;
        exp_dout = '0; exp_valid = 1'b0; exp_ovf = 1'b0;

        // 1: reset and idle
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);

        // 2: three pushes, three pops in order
        step(1'b0, 1'b1, 32'hA5, 1'b0);
        step(1'b0, 1'b1, 32'h11, 1'b0);
        step(1'b0, 1'b1, 32'h22, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("t2_first", DATA_OUT, 32'hA5);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("t2_last", DATA_OUT, 32'h22);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);

        // 3: fill, overflow attempt, drain
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, DW'(i), 1'b0);
        chk("t3_count_full", DW'(TX_COUNT), 32'd16);
        step(1'b0, 1'b1, 32'hDEAD, 1'b0);
        chk("t3_count_after_drop", DW'(TX_COUNT), 32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            chk("t3_order", DATA_OUT, DW'(i));
        end

        // 4: full FIFO with simultaneous push and pop
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, DW'(i), 1'b0);
        step(1'b0, 1'b1, 32'h77, 1'b1);
        chk("t4_oldest", DATA_OUT, 32'h0);
        chk("t4_full_kept", DW'(TX_FULL), 32'd1);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, '0, 1'b1);
        chk("t4_last_is_77", DATA_OUT, 32'h77);

        // 5: empty FIFO with simultaneous push and pop
        step(1'b0, 1'b1, 32'h55, 1'b1);
        chk("t5_no_bypass", DW'(DATA_VALID), 32'd0);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("t5_pop", DATA_OUT, 32'h55);

        // 6: pointer wrap traffic, then reset with 5 entries held
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, DW'(32'h100 + i), (i >= 5));
        chk("t6_held", DW'(TX_COUNT), 32'd5);
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 32'hBEEF, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("t6_new_data", DATA_OUT, 32'hBEEF);
        step(1'b0, 1'b0, '0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
